// File: rtl/dbg_probe_scanner_pkg.sv
// Shared types and width helpers for the debug-probe scanner.
// Widths are derived from channel counts so one package serves every build.
package dbg_probe_scanner_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_e;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dbg_probe_scanner_if.sv
// Datapath observation and snapshot read port of the probe scanner.
// master: the scanner; slave: datapath probes plus host reader.
interface dbg_probe_scanner_if
    import dbg_probe_scanner_pkg::*;
#(
    parameter int SSD_W = 13,
    parameter int LED_W = 16,
    parameter int N_SSD = 12,
    parameter int N_LED = 3
);
    localparam int SS_W   = sel_w(N_SSD);
    localparam int LS_W   = sel_w(N_LED);
    localparam int AW     = sel_w(N_SSD + N_LED);
    localparam int DATA_W = max_w(SSD_W, LED_W);

    logic [SS_W-1:0]   ssd_sel;
    logic [LS_W-1:0]   led_sel;
    logic [SSD_W-1:0]  ssd_in;
    logic [LED_W-1:0]  led_in;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output ssd_sel, led_sel, rd_data, rd_valid,
        input  ssd_in, led_in, rd_addr
    );

    modport slave (
        input  ssd_sel, led_sel, rd_data, rd_valid,
        output ssd_in, led_in, rd_addr
    );

endinterface

// File: rtl/dbg_snap_buf.sv
// Snapshot register file: one write port, registered read,
// per-entry valid bits with a clear-all. Storage itself is never reset.
module dbg_snap_buf #(
    parameter int DEPTH  = 15,
    parameter int DATA_W = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              clr,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [AW-1:0]     ra,
    output logic [DATA_W-1:0] rd,
    output logic              rv
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              rv_q, rv_d;
    logic              in_rng;

    assign in_rng = (int'(ra) < DEPTH);
    assign rd     = rd_q;
    assign rv     = rv_q;

    always_comb begin
        vld_d = vld_q;
        if (clr) vld_d = '0;
        if (we)  vld_d[wa] = 1'b1;
        rd_d = '0;
        rv_d = 1'b0;
        // Read sees pre-write contents when addressing the entry being written
        if (in_rng) begin
            rd_d = mem_q[ra];
            rv_d = vld_q[ra];
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[wa] <= wd;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
            rd_q  <= '0;
            rv_q  <= 1'b0;
        end else begin
            vld_q <= vld_d;
            rd_q  <= rd_d;
            rv_q  <= rv_d;
        end
    end

endmodule

// File: rtl/dbg_probe_scanner.sv
// Debug-probe sequencer: steps datapath observation selects,
// waits a settle time per channel and snapshots each probe value.
module dbg_probe_scanner
    import dbg_probe_scanner_pkg::*;
#(
    parameter int SSD_W   = 13,
    parameter int LED_W   = 16,
    parameter int N_SSD   = 12,
    parameter int N_LED   = 3,
    parameter int SETTLE  = 2,
    parameter int FRAME_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cont,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               overrun,
    output logic [FRAME_W-1:0] frame_cnt,
    dbg_probe_scanner_if.master pif
);
    localparam int DEPTH  = N_SSD + N_LED;
    localparam int CH_W   = sel_w(DEPTH);
    localparam int SS_W   = sel_w(N_SSD);
    localparam int LS_W   = sel_w(N_LED);
    localparam int DATA_W = max_w(SSD_W, LED_W);
    localparam int CNT_W  = sel_w(SETTLE);

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]  CH_LED0  = CH_W'(N_SSD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    state_e             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               ovr_q, ovr_d;
    logic               we, clr, is_led;
    logic [DATA_W-1:0]  wd;

    assign busy      = (state_q != S_IDLE);
    assign overrun   = ovr_q;
    assign frame_cnt = frame_q;
    assign is_led    = (ch_q >= CH_LED0);
    assign wd        = is_led ? DATA_W'(pif.led_in)
                              : DATA_W'(pif.ssd_in);

    always_comb begin
        pif.ssd_sel = '0;
        pif.led_sel = '0;
        if (state_q == S_SETTLE || state_q == S_CAPTURE) begin
            if (is_led) pif.led_sel = LS_W'(ch_q - CH_LED0);
            else        pif.ssd_sel = SS_W'(ch_q);
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        ovr_d   = ovr_q;
        we      = 1'b0;
        clr     = 1'b0;
        done    = 1'b0;
        if (start && busy) ovr_d = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    ch_d    = '0;
                    cnt_d   = '0;
                    clr     = 1'b1;
                    ovr_d   = 1'b0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_LAST) state_d = S_CAPTURE;
                else cnt_d = cnt_q + CNT_W'(1);
            end
            S_CAPTURE: begin
                we    = 1'b1;
                cnt_d = '0;
                if (ch_q == CH_LAST) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                frame_d = frame_q + FRAME_W'(1);
                ch_d    = '0;
                cnt_d   = '0;
                clr     = cont;
                state_d = cont ? S_SETTLE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort freezes the snapshot as-is: no write, no clear, no frame
        if (abort && busy) begin
            state_d = S_IDLE;
            ch_d    = '0;
            cnt_d   = '0;
            frame_d = frame_q;
            we      = 1'b0;
            clr     = 1'b0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            ovr_q   <= ovr_d;
        end
    end

    dbg_snap_buf #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (CH_W)
    ) u_buf (
        .clk (clk),
        .rst (rst),
        .we  (we),
        .clr (clr),
        .wa  (ch_q),
        .wd  (wd),
        .ra  (pif.rd_addr),
        .rd  (pif.rd_data),
        .rv  (pif.rd_valid)
    );

endmodule
